// File: rtl/axis_frame_playback_if.sv
// AXI4-Stream bundle used by the frame playback source.
// The playback block drives it through the master modport.
interface axis_frame_playback_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_frame_playback.sv
// Frame RAM playback source: preloaded samples are streamed out on AXIS,
// one frame per tlast, through a 1-cycle RAM read and a 2-entry skid buffer.
module axis_frame_playback #(
    parameter int WIDTH   = 16,
    parameter int FFT_LEN = 64,
    parameter int FRAMES  = 32,
    parameter int SAMP    = FRAMES * FFT_LEN,
    parameter int AW      = $clog2(SAMP)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic                 start,
    input  logic                 loop,
    input  logic                 abort,
    axis_frame_playback_if.master m_axis,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          frame_cnt
);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          abort_q, abort_d;
    logic          done_q, done_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic          rd_en;
    logic          rd_end;
    logic          rd_fend;

    logic [DW-1:0] mem [SAMP];
    logic [DW-1:0] ram_q;
    logic          rd_vld_q;
    logic          rd_last_q;

    logic [DW-1:0] b0_q, b0_d, b1_q, b1_d;
    logic          b0l_q, b0l_d, b1l_q, b1l_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    cnt_kept;
    logic          push;
    logic          pop;
    logic          tvalid;
    logic [2:0]    occ;
    logic          credit;

    assign rd_end  = (rd_addr_q == AW'(SAMP - 1));
    assign rd_fend = ((32'(rd_addr_q) % FFT_LEN) == FFT_LEN - 1);

    assign tvalid = (cnt_q != 2'd0);
    assign pop    = tvalid & m_axis.tready;
    assign push   = rd_vld_q;

    // Count the beat leaving this cycle so 1 beat/clock needs only 2 slots.
    assign occ    = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
    assign credit = (occ < 3'd2);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        abort_d     = abort_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (pop && b0l_q) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d     = FILL;
                    rd_addr_d   = '0;
                    abort_d     = abort;
                    frame_cnt_d = '0;
                end
            end
            FILL: begin
                rd_en   = 1'b1;
                abort_d = abort_q | abort;
            end
            STREAM: begin
                rd_en   = credit;
                abort_d = abort_q | abort;
            end
            DRAIN: begin
                if (cnt_q == 2'd0 && !rd_vld_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    abort_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // An abort only takes effect on a frame-end read, so frames stay whole.
        if (rd_en) begin
            if ((rd_end && !loop) || (rd_fend && (abort_q || abort))) begin
                state_d = DRAIN;
            end else begin
                state_d   = STREAM;
                rd_addr_d = rd_end ? '0 : rd_addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Storage is deliberately left out of reset so preloaded frames survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en;
            if (rd_en) begin
                rd_last_q <= rd_fend;
            end
        end
    end

    always_comb begin
        b0_d     = b0_q;
        b0l_d    = b0l_q;
        b1_d     = b1_q;
        b1l_d    = b1l_q;
        cnt_kept = cnt_q - 2'(pop);
        cnt_d    = cnt_kept + 2'(push);
        if (pop) begin
            b0_d  = b1_q;
            b0l_d = b1l_q;
        end
        if (push) begin
            if (cnt_kept == 2'd0) begin
                b0_d  = ram_q;
                b0l_d = rd_last_q;
            end else begin
                b1_d  = ram_q;
                b1l_d = rd_last_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_q  <= '0;
            b0l_q <= 1'b0;
            b1_q  <= '0;
            b1l_q <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            b0_q  <= b0_d;
            b0l_q <= b0l_d;
            b1_q  <= b1_d;
            b1l_q <= b1l_d;
            cnt_q <= cnt_d;
        end
    end

    assign m_axis.tdata  = b0_q;
    assign m_axis.tlast  = b0l_q;
    assign m_axis.tvalid = tvalid;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_axis_frame_playback.sv
// Scoreboard bench for axis_frame_playback: expected beats come from a
// sample-array model and are checked by an independent AXIS monitor.
module tb_axis_frame_playback;
    localparam int W  = 16;
    localparam int L  = 64;
    localparam int F  = 32;
    localparam int S  = L * F;
    localparam int AW = $clog2(S);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          start;
    logic          loop;
    logic          abort;
    logic          busy;
    logic          done;
    logic [31:0]   frame_cnt;

    axis_frame_playback_if #(.DW(2 * W)) m_axis ();

    axis_frame_playback #(
        .WIDTH  (W),
        .FFT_LEN(L),
        .FRAMES (F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .loop     (loop),
        .abort    (abort),
        .m_axis   (m_axis),
        .busy     (busy),
        .done     (done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          beats = 0;
    int          done_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    bit          rnd_ready = 1'b0;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic [31:0] model [S];
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic        done_prev = 1'b0;
    logic [31:0] pd = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        m_axis.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: holds while stalled, scoreboard pop per handshake, done width.
    always @(negedge clk) begin
        if (rst) begin
            pv        = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold", {m_axis.tvalid, m_axis.tlast, m_axis.tdata},
                    {1'b1, pl, pd});
            end
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_beat: got tdata %0h, expected no beat",
                             m_axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", beats),
                        {m_axis.tlast, m_axis.tdata}, e);
                end
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
            end
            if (done) begin
                chk("done_width", done_prev, 0);
                done_cnt++;
                done_cyc = cyc;
            end
            done_prev = done;
            pv = m_axis.tvalid;
            pr = m_axis.tready;
            pd = m_axis.tdata;
            pl = m_axis.tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(bit rnd);
        for (int i = 0; i < S; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = rnd ? $urandom : 32'(i);
            model[i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic play(int n, bit chk_lat);
        beats = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            a = i % S;
            exp_q.push_back({1'(a % L == L - 1), model[a]});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            @(negedge clk);
            #1 chk("lat_early", m_axis.tvalid, 0);
            @(negedge clk);
            #1 chk("lat_valid", m_axis.tvalid, 1);
            tick();
        end
    endtask

    task automatic wait_beats(int n, int budget);
        for (int i = 0; i < budget && beats < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("beats_reached", beats >= n, 1);
    endtask

    task automatic wait_done(int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", done_cnt - d0, 1);
        repeat (5) tick();
        chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic end_checks(string nm, int fc);
        chk({nm, "_frame_cnt"}, frame_cnt, fc);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_tvalid"}, m_axis.tvalid, 0);
        chk({nm, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        loop    = 1'b0;
        abort   = 1'b0;
        repeat (3) tick();
        chk("rst_state", {m_axis.tvalid, m_axis.tlast, m_axis.tdata,
                          busy, done, frame_cnt}, 0);
        rst = 1'b0;
        tick();

        // Full playback, ready held high
        preload(1'b0);
        play(S, 1'b1);
        wait_done(3000);
        chk("s1_gapless", last_cyc - first_cyc, S - 1);
        chk("s1_done_lag", done_cyc - last_cyc, 2);
        end_checks("s1", F);

        // Random backpressure with a start reissued while busy
        rnd_ready = 1'b1;
        play(S, 1'b0);
        wait_beats(300, 2000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10000);
        end_checks("s2", F);
        rnd_ready = 1'b0;
        tick();

        // Loop wraps without a bubble, then ends at the next wrap
        begin
            int d0;
            d0   = done_cnt;
            loop = 1'b1;
            play(2 * S, 1'b0);
            wait_beats(S + L, 3000);
            @(posedge clk);
            #1 chk("s3_frame_cnt_33", frame_cnt, F + 1);
            chk("s3_no_done", done_cnt - d0, 0);
            loop = 1'b0;
            wait_done(3000);
            chk("s3_gapless", last_cyc - first_cyc, 2 * S - 1);
            end_checks("s3", 2 * F);
        end

        // Abort during beat 100 finishes frame 1 only
        play(2 * L, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (m_axis.tvalid && m_axis.tready && m_axis.tdata == 32'd100)
                found = 1'b1;
        end
        chk("s4_trigger", found, 1);
        #1 abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(500);
        repeat (20) tick();
        chk("s4_beats", beats, 2 * L);
        end_checks("s4", 2);

        // Asynchronous reset mid-stream, then replay from 0
        play(S, 1'b0);
        wait_beats(500, 1000);
        rst = 1'b1;
        #1;
        chk("s5_rst_async", {m_axis.tvalid, busy, frame_cnt}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        play(S, 1'b1);
        wait_done(3000);
        end_checks("s5", F);

        // RAM write in IDLE is picked up by the next playback
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = 32'hABCD;
        model[5] = 32'hABCD;
        tick();
        wr_en = 1'b0;
        play(S, 1'b0);
        wait_done(3000);
        end_checks("s6", F);

        // Random contents; abort together with start stops after frame 0
        preload(1'b1);
        rnd_ready = 1'b1;
        abort = 1'b1;
        play(L, 1'b0);
        abort = 1'b0;
        wait_done(1000);
        repeat (20) tick();
        end_checks("s7", 1);

        // Random contents, full run under backpressure
        play(S, 1'b0);
        wait_done(10000);
        end_checks("s8", F);
        rnd_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
